// File: rtl/ahb_addr_decoder.sv
// AHB-Lite address decoder and response mux with a built-in default slave.
// Build with AHB_DECODER_TIMEOUT_EN to abort data phases that stall too long.
module ahb_addr_decoder #(
    parameter int NUM_SLAVES     = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             hclk,
    input  logic                             hreset,
    input  logic [ADDR_WIDTH-1:0]            haddr,
    input  logic [1:0]                       htrans,
    output logic [NUM_SLAVES-1:0]            hsel,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_s,
    input  logic [NUM_SLAVES-1:0]            hreadyout_s,
    input  logic [NUM_SLAVES-1:0]            hresp_s,
    output logic [DATA_WIDTH-1:0]            hrdata,
    output logic                             hready,
    output logic                             hresp
);

    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_ERR1 = 2'd1;
    localparam logic [1:0] D_ERR2 = 2'd2;

    logic [IDX_W-1:0]    idx;
    logic                dec_default;
    logic                start_err;
    logic [NUM_SLAVES:0] dsel_q, dsel_d;
    logic [1:0]          state_q, state_d;
    logic                unused_addr;

    assign idx         = haddr[ADDR_WIDTH-1 -: IDX_W];
    assign unused_addr = ^{haddr[ADDR_WIDTH-IDX_W-1:0], htrans[0]};

    always_comb begin
        hsel = '0;
        for (int k = 0; k < NUM_SLAVES; k++)
            if (int'(idx) == k + 1) hsel[k] = 1'b1;
    end

    // Index 0 and anything above the last slave both fall to the default slave
    assign dec_default = ~|hsel;
    assign start_err   = hready && dec_default && htrans[1];

    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = 1'b0;
        if (dsel_q[0]) begin
            hready = (state_q != D_ERR1);
            hresp  = (state_q != D_IDLE);
        end else begin
            for (int k = 0; k < NUM_SLAVES; k++)
                if (dsel_q[k+1]) begin
                    hrdata = hrdata_s[k*DATA_WIDTH +: DATA_WIDTH];
                    hready = hreadyout_s[k];
                    hresp  = hresp_s[k];
                end
        end
    end

`ifdef AHB_DECODER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_q, wait_d;
    logic             stall, timeout;

    assign stall   = !dsel_q[0] && !hready;
    // Fires on the edge that ends the TIMEOUT_CYCLES-th stalled cycle
    assign timeout = stall && (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_d = '0;
        if (stall && !timeout) wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) wait_q <= '0;
        else        wait_q <= wait_d;
    end
`else
    logic timeout;
    assign timeout = 1'b0;
`endif

    always_comb begin
        dsel_d  = hready ? {hsel, dec_default} : dsel_q;
        state_d = state_q;
        case (state_q)
            D_IDLE:  if (start_err) state_d = D_ERR1;
            D_ERR1:  state_d = D_ERR2;
            D_ERR2:  state_d = start_err ? D_ERR1 : D_IDLE;
            default: state_d = D_IDLE;
        endcase
        if (timeout) begin
            dsel_d  = {{NUM_SLAVES{1'b0}}, 1'b1};
            state_d = D_ERR1;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            dsel_q  <= {{NUM_SLAVES{1'b0}}, 1'b1};
            state_q <= D_IDLE;
        end else begin
            dsel_q  <= dsel_d;
            state_q <= state_d;
        end
    end

endmodule
